gpr_file_sb: RTL and testbench
==============================

GPR_FILE_SB -- requirements
Module: gpr_file_sb

Interface
REQ-001 Parameter DATA_W, 32, width of every GPR and of hi and lo.
REQ-002 Parameter NUM_REGS, 32, GPR count (power of two); ADDR_W = clog2(NUM_REGS).
REQ-003 Parameter NUM_RD, 4, number of read ports.
REQ-004 Parameter NUM_WR, 2, number of GPR write ports.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at slice i.
REQ-008 rd_data  out  NUM_RD*DATA_W  read data, combinational.
REQ-009 rd_busy  out  NUM_RD  port i operand pending (not yet forwardable).
REQ-010 wr_en / wr_addr / wr_data  in  NUM_WR / NUM_WR*ADDR_W / NUM_WR*DATA_W  writeback ports.
REQ-011 hl_we / hl_data  in  1 / 2*DATA_W  hi/lo paired write; hi is the upper half.
REQ-012 hi_q / lo_q / hl_busy  out  DATA_W / DATA_W / 1  hi, lo (hl_data bypassed when hl_we) and hi/lo pending.
REQ-013 iss_valid / iss_addr  in  1 / ADDR_W  issue of an instruction that will write GPR iss_addr.
REQ-014 iss_hl  in  1  issue of an instruction that will write hi/lo.
REQ-015 flush  in  1  discard all pending-write marks.

Function
REQ-016 Reg 0 SHALL read 0, ignore writes, and never be busy.
REQ-017 rd_data[i] SHALL equal wr_data of the highest-index port k with wr_en[k] and wr_addr[k]==rd_addr[i], else the stored value (same-cycle write-through).
REQ-018 On an edge, every enabled write port SHALL update its register; on an address collision the highest-index port wins.
REQ-019 Scoreboard busy[NUM_REGS] and busy_hl SHALL be single bits.
REQ-020 Edge with iss_valid and iss_addr!=0 SHALL set busy[iss_addr]; iss_hl SHALL set busy_hl.
REQ-021 Edge with any wr_en[k] to addr a SHALL clear busy[a] unless an issue to a occurs in the same cycle; a same-cycle issue wins (busy stays 1).
REQ-022 Edge with hl_we SHALL clear busy_hl unless iss_hl is also set (set wins).
REQ-023 rd_busy[i] SHALL equal busy[rd_addr[i]] AND NOT (any wr_en[k] with wr_addr[k]==rd_addr[i]); hl_busy SHALL equal busy_hl AND NOT hl_we.
REQ-024 flush SHALL clear all busy bits on the edge and SHALL override a same-cycle issue; writes still commit.
REQ-025 Issue does not alter register contents; a write to a non-busy register SHALL still commit.
REQ-026 Latency: write visible combinationally in the same cycle (bypass), stored from the next cycle.

Reset
REQ-027 rst SHALL clear all GPRs, hi, lo, busy[] and busy_hl on the edge, overriding every write, issue and flush.
REQ-028 After reset, every rd_data, hi_q and lo_q SHALL be 0 and every rd_busy and hl_busy SHALL be 0 until the next enable.
REQ-029 rst asserted mid-operation SHALL drop all pending marks; in-flight writebacks arriving after rst deasserts SHALL write normally.

Structure
REQ-030 The default widths and the hi/lo pair width constant SHALL live in the shared cpu package.
REQ-031 Scoreboard bits SHALL be a sub-module gpr_scoreboard (issue/clear/flush/lookup); storage and bypass SHALL stay in gpr_file_sb.

Verification
REQ-032 Reset, then read all ports at addr 5 -> rd_data 0, rd_busy 0.
REQ-033 wr_en[0]=1 addr 3 data 0xDEADBEEF, rd_addr[0]=3 same cycle -> rd_data 0xDEADBEEF; next cycle stored value 0xDEADBEEF.
REQ-034 Ports 0 and 1 both write addr 7 (0x11, 0x22) -> both bypass and stored value 0x22.
REQ-035 Issue addr 9; next cycle read 9 -> rd_busy 1; writeback 9 with 0x55 -> same cycle rd_busy 0, rd_data 0x55; next cycle busy 0.
REQ-036 Issue addr 9 and writeback addr 9 in the same cycle -> busy[9]=1 afterwards; flush next cycle -> busy 0.
REQ-037 Write addr 0 with 0xFFFFFFFF and issue addr 0 -> reads 0, rd_busy 0; iss_hl then hl_we 0x00000001_00000002 -> hl_busy 0 that cycle, hi_q 1, lo_q 2.

Source files
------------

// File: rtl/gpr_file_sb_pkg.sv
// Shared cpu package: default register-file geometry and the hi/lo pair width.
package gpr_file_sb_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int NUM_RD_DEF   = 4;
  localparam int NUM_WR_DEF   = 2;

  // hi and lo travel together as one bus, hi in the upper half
  function automatic int pair_width(input int data_w);
    return 2 * data_w;
  endfunction

  localparam int HL_W_DEF = pair_width(DATA_W_DEF);

endpackage

// File: rtl/gpr_file_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per GPR plus one for hi/lo.
// Set on issue, cleared by writeback or flush; lookup masks same-cycle writebacks.
module gpr_scoreboard
  import gpr_file_sb_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     iss_hl,
  input  logic                     flush,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     hl_we,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     hl_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic                r_busy_hl;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_busy_hl_nxt;
  logic [NUM_RD-1:0]   w_hit;

  // Ordering encodes priority: writeback clear < issue set < flush clear.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k]) w_busy_nxt[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (iss_valid && iss_addr != '0) w_busy_nxt[iss_addr] = 1'b1;
    if (flush) w_busy_nxt = '0;
    w_busy_nxt[0] = 1'b0;

    w_busy_hl_nxt = r_busy_hl;
    if (hl_we)  w_busy_hl_nxt = 1'b0;
    if (iss_hl) w_busy_hl_nxt = 1'b1;
    if (flush)  w_busy_hl_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= '0;
      r_busy_hl <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_busy_hl <= w_busy_hl_nxt;
    end
  end

  always_comb begin
    w_hit   = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])
          w_hit[i] = 1'b1;
      end
      rd_busy[i] = r_busy[rd_addr[i*ADDR_W +: ADDR_W]] & ~w_hit[i];
    end
    hl_busy = r_busy_hl & ~hl_we;
  end

endmodule

// File: rtl/gpr_file_sb.sv
// Multi-ported GPR file with hi/lo pair, same-cycle write bypass and a
// pending-write scoreboard; reg 0 is hardwired to zero.
module gpr_file_sb
  import gpr_file_sb_pkg::*;
#(
  parameter int  DATA_W   = DATA_W_DEF,
  parameter int  NUM_REGS = NUM_REGS_DEF,
  parameter int  NUM_RD   = NUM_RD_DEF,
  parameter int  NUM_WR   = NUM_WR_DEF,
  localparam int ADDR_W   = $clog2(NUM_REGS),
  localparam int PAIR_W   = pair_width(DATA_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     hl_we,
  input  logic [PAIR_W-1:0]        hl_data,
  output logic [DATA_W-1:0]        hi_q,
  output logic [DATA_W-1:0]        lo_q,
  output logic                     hl_busy,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     iss_hl,
  input  logic                     flush
);

  logic [DATA_W-1:0] r_gpr [NUM_REGS];
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] w_rd_val [NUM_RD];

  // Ascending port order lets the highest-index port win a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_gpr[r] <= '0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] != '0)
          r_gpr[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
      end
      if (hl_we) begin
        r_hi <= hl_data[PAIR_W-1 -: DATA_W];
        r_lo <= hl_data[DATA_W-1:0];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd_val[i] = r_gpr[rd_addr[i*ADDR_W +: ADDR_W]];
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])
          w_rd_val[i] = wr_data[k*DATA_W +: DATA_W];
      end
      if (rd_addr[i*ADDR_W +: ADDR_W] == '0) w_rd_val[i] = '0;
      rd_data[i*DATA_W +: DATA_W] = w_rd_val[i];
    end
  end

  assign hi_q = hl_we ? hl_data[PAIR_W-1 -: DATA_W] : r_hi;
  assign lo_q = hl_we ? hl_data[DATA_W-1:0]         : r_lo;

  gpr_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_hl    (iss_hl),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .hl_we     (hl_we),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy),
    .hl_busy   (hl_busy)
  );

endmodule

// File: tb/tb_gpr_file_sb.sv
// Bench for gpr_file_sb: directed vector table, hand sequences, random vs. model.
module tb_gpr_file_sb;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int AW  = 5;
  localparam int NV  = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              hl_we;
  logic [2*DW-1:0]   hl_data;
  logic [DW-1:0]     hi_q, lo_q;
  logic              hl_busy;
  logic              iss_valid;
  logic [AW-1:0]     iss_addr;
  logic              iss_hl;
  logic              flush;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gpr_file_sb dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .hl_we(hl_we), .hl_data(hl_data),
    .hi_q(hi_q), .lo_q(lo_q), .hl_busy(hl_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_hl(iss_hl),
    .flush(flush)
  );

  typedef struct {
    logic [AW-1:0] ra;
    logic [1:0]    we;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic          iv;
    logic [AW-1:0] ia;
    logic          fl;
    logic [DW-1:0] ed;
    logic          eb;
  } vec_t;

  vec_t tbl [NV];

  // reference state
  logic [DW-1:0] m_gpr [NR];
  bit            m_busy [NR];
  logic [DW-1:0] m_hi, m_lo;
  bit            m_busy_hl;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [AW-1:0] ra, input logic [1:0] we,
                              input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                              input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                              input logic iv, input logic [AW-1:0] ia, input logic fl,
                              input logic [DW-1:0] ed, input logic eb);
    vec_t v;
    v.ra = ra; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.iv = iv; v.ia = ia; v.fl = fl; v.ed = ed; v.eb = eb;
    return v;
  endfunction

  task automatic idle();
    rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    hl_we = 1'b0; hl_data = '0; iss_valid = 1'b0; iss_addr = '0;
    iss_hl = 1'b0; flush = 1'b0; rd_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_ports(input string nm, input logic [DW-1:0] ed, input logic eb);
    for (int i = 0; i < NRD; i++) begin
      chk($sformatf("%s data p%0d", nm, i), 64'(rd_data[i*DW +: DW]), 64'(ed));
      chk($sformatf("%s busy p%0d", nm, i), 64'(rd_busy[i]), 64'(eb));
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = m_gpr[a];
    for (int k = 0; k < NWR; k++)
      if (wr_en[k] && wr_addr[k*AW +: AW] == a) v = wr_data[k*DW +: DW];
    if (a == 0) v = '0;
    return v;
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < NWR; k++)
      if (wr_en[k] && wr_addr[k*AW +: AW] == a) hit = 1'b1;
    return m_busy[a] && !hit;
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        m_gpr[r] = '0;
        m_busy[r] = 1'b0;
      end
      m_hi = '0; m_lo = '0; m_busy_hl = 1'b0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k]) begin
          if (wr_addr[k*AW +: AW] != 0) m_gpr[wr_addr[k*AW +: AW]] = wr_data[k*DW +: DW];
          m_busy[wr_addr[k*AW +: AW]] = 1'b0;
        end
      end
      if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      if (hl_we) begin
        m_hi = hl_data[2*DW-1:DW];
        m_lo = hl_data[DW-1:0];
        m_busy_hl = 1'b0;
      end
      if (iss_hl) m_busy_hl = 1'b1;
      if (flush) begin
        for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
        m_busy_hl = 1'b0;
      end
    end
  endtask

  initial begin
    tbl[0]  = mk(5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    tbl[1]  = mk(3, 2'b01, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0);
    tbl[2]  = mk(3, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0);
    tbl[3]  = mk(7, 2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 0, 32'h22, 0);
    tbl[4]  = mk(7, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h22, 0);
    tbl[5]  = mk(9, 2'b00, 0, 0, 0, 0, 1, 9, 0, 32'h0, 0);
    tbl[6]  = mk(9, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
    tbl[7]  = mk(9, 2'b01, 9, 32'h55, 0, 0, 0, 0, 0, 32'h55, 0);
    tbl[8]  = mk(9, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h55, 0);
    tbl[9]  = mk(9, 2'b01, 9, 32'h66, 0, 0, 1, 9, 0, 32'h66, 0);
    tbl[10] = mk(9, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h66, 1);
    tbl[11] = mk(9, 2'b00, 0, 0, 0, 0, 0, 0, 1, 32'h66, 1);
    tbl[12] = mk(9, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h66, 0);
    tbl[13] = mk(0, 2'b01, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 32'h0, 0);
    tbl[14] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);

    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    for (int n = 0; n < NV; n++) begin
      idle();
      rd_addr   = {NRD{tbl[n].ra}};
      wr_en     = tbl[n].we;
      wr_addr   = {tbl[n].wa1, tbl[n].wa0};
      wr_data   = {tbl[n].wd1, tbl[n].wd0};
      iss_valid = tbl[n].iv;
      iss_addr  = tbl[n].ia;
      flush     = tbl[n].fl;
      #2;
      chk_all_ports($sformatf("vec%0d", n), tbl[n].ed, tbl[n].eb);
      tick();
    end

    // hi/lo: issue, pending, writeback bypass, stored
    idle(); iss_hl = 1'b1; #2;
    chk("hl issue cycle busy", 64'(hl_busy), 64'd0);
    tick();
    idle(); #2;
    chk("hl pending busy", 64'(hl_busy), 64'd1);
    tick();
    idle(); hl_we = 1'b1; hl_data = 64'h00000001_00000002; #2;
    chk("hl wb busy", 64'(hl_busy), 64'd0);
    chk("hl wb hi", 64'(hi_q), 64'd1);
    chk("hl wb lo", 64'(lo_q), 64'd2);
    tick();
    idle(); #2;
    chk("hl stored hi", 64'(hi_q), 64'd1);
    chk("hl stored lo", 64'(lo_q), 64'd2);
    chk("hl stored busy", 64'(hl_busy), 64'd0);
    idle(); iss_hl = 1'b1; hl_we = 1'b1; hl_data = 64'h3_0000_0004;
    tick();
    idle(); #2;
    chk("hl set wins", 64'(hl_busy), 64'd1);
    tick();

    // reset mid-operation overrides write and issue
    idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'd0, 32'hAA};
    iss_valid = 1'b1; iss_addr = 5'd4;
    tick();
    idle(); rst = 1'b1; wr_en = 2'b10; wr_addr = {5'd13, 5'd0}; wr_data = {32'hBB, 32'd0};
    iss_valid = 1'b1; iss_addr = 5'd5; iss_hl = 1'b1; hl_we = 1'b1; hl_data = 64'h9_0000_0009;
    tick();
    idle(); rd_addr = {5'd5, 5'd4, 5'd13, 5'd12}; #2;
    for (int i = 0; i < NRD; i++) begin
      chk($sformatf("rst data p%0d", i), 64'(rd_data[i*DW +: DW]), 64'd0);
      chk($sformatf("rst busy p%0d", i), 64'(rd_busy[i]), 64'd0);
    end
    chk("rst hi", 64'(hi_q), 64'd0);
    chk("rst lo", 64'(lo_q), 64'd0);
    chk("rst hl busy", 64'(hl_busy), 64'd0);
    idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'd0, 32'h77};
    tick();
    idle(); rd_addr = {NRD{5'd4}}; #2;
    chk_all_ports("post-rst wb", 32'h77, 1'b0);
    tick();

    // randomized phase against the model
    idle(); rst = 1'b1;
    model_edge();
    tick();
    for (int c = 0; c < 600; c++) begin
      logic [AW-1:0] ra;
      idle();
      rst       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      iss_valid = $urandom_range(0, 1);
      iss_addr  = AW'($urandom_range(0, 11));
      iss_hl    = ($urandom_range(0, 3) == 0);
      hl_we     = ($urandom_range(0, 2) == 0);
      hl_data   = {$urandom, $urandom};
      wr_en     = NWR'($urandom_range(0, 3));
      for (int k = 0; k < NWR; k++) begin
        wr_addr[k*AW +: AW] = AW'($urandom_range(0, 11));
        wr_data[k*DW +: DW] = $urandom;
      end
      for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 11));
      #2;
      for (int i = 0; i < NRD; i++) begin
        ra = rd_addr[i*AW +: AW];
        chk($sformatf("rnd c%0d data p%0d a%0d", c, i, ra), 64'(rd_data[i*DW +: DW]), 64'(exp_rd(ra)));
        chk($sformatf("rnd c%0d busy p%0d a%0d", c, i, ra), 64'(rd_busy[i]), 64'(exp_busy(ra)));
      end
      chk($sformatf("rnd c%0d hi", c), 64'(hi_q), 64'(hl_we ? hl_data[2*DW-1:DW] : m_hi));
      chk($sformatf("rnd c%0d lo", c), 64'(lo_q), 64'(hl_we ? hl_data[DW-1:0] : m_lo));
      chk($sformatf("rnd c%0d hl busy", c), 64'(hl_busy), 64'(m_busy_hl && !hl_we));
      model_edge();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
